melody_seq: RTL

- Parametrised, RAM-programmable melody sequencer; next generation of the fixed-table note player.
- Per-step note period, duration and rest flag live in an internal song memory loaded through a write port.
- Adds start/stop control, loop mode, an articulation gap between notes, and a done pulse.
- Sits between board-level controls and the buzzer/speaker pin; replaces the hard-wired per-note divider instances and the step mux.

---
 rtl/melody_seq_if.sv | 29 ++
 rtl/melody_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/melody_seq_if.sv
// Control, song-memory write and audio output bundle for the melody sequencer.
// The controller side drives song writes and transport; the player drives audio and status.
interface melody_seq_if #(
  parameter int AW    = 5,
  parameter int DIV_W = 16,
  parameter int DUR_W = 4
);
  logic                   we;
  logic [AW-1:0]          waddr;
  logic [DUR_W+DIV_W:0]   wdata;
  logic [AW:0]            len;
  logic                   loop;
  logic                   start;
  logic                   stop;
  logic                   tone;
  logic [AW-1:0]          step;
  logic                   busy;
  logic                   done;

  modport master (
    output we, waddr, wdata, len, loop, start, stop,
    input  tone, step, busy, done
  );

  modport slave (
    input  we, waddr, wdata, len, loop, start, stop,
    output tone, step, busy, done
  );
endinterface

// File: rtl/melody_seq.sv
// RAM-programmable melody sequencer: plays {rest, dur, half_period} steps from song memory
// as a square wave, with start/stop, loop mode, a silent gap after each step and a done pulse.
module melody_seq #(
  parameter int STEPS     = 32,
  parameter int AW        = 5,
  parameter int DIV_W     = 16,
  parameter int DUR_W     = 4,
  parameter int TICK_CYC  = 2500000,
  parameter int GAP_TICKS = 1
) (
  input logic        clk,
  input logic        rst,
  melody_seq_if.slave bus
);

  localparam int WD    = 1 + DUR_W + DIV_W;
  localparam int PRE_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int TK_W  = (DUR_W > GAP_W) ? DUR_W : GAP_W;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYC - 1);
  localparam logic [TK_W-1:0]  GAP_LAST = TK_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [AW:0]      STEPS_L  = (AW+1)'(STEPS);

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

  state_t            state;
  logic [WD-1:0]     mem [STEPS];
  logic [WD-1:0]     rd;
  logic [DIV_W-1:0]  half_r;
  logic [DUR_W-1:0]  dur_r;
  logic              rest_r;
  logic [DIV_W-1:0]  tcnt;
  logic [PRE_W-1:0]  pre;
  logic [TK_W-1:0]   ticks;
  logic [TK_W-1:0]   dur_last;
  logic [AW:0]       len_r;
  logic [AW:0]       len_clamp;
  logic [AW-1:0]     step_r;
  logic              tone_r, busy_r, done_r;
  logic              tick_wrap, last_step, adv;

  assign rd        = mem[step_r];
  assign len_clamp = (bus.len > STEPS_L) ? STEPS_L : bus.len;
  assign tick_wrap = (pre == PRE_LAST);
  assign dur_last  = TK_W'(dur_r - 1'b1);
  assign last_step = ({1'b0, step_r} == (len_r - 1'b1));
  // End of a step: last PLAY tick when there is no gap, otherwise last GAP tick.
  assign adv = tick_wrap &&
               (((state == PLAY) && (GAP_TICKS == 0) && (ticks == dur_last)) ||
                ((state == GAP) && (ticks == GAP_LAST)));

  always_ff @(posedge clk) begin
    if (bus.we) mem[bus.waddr] <= bus.wdata;
  end

  // Step data is captured only in LOAD, so live writes apply from the next LOAD.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      half_r <= rd[DIV_W-1:0];
      dur_r  <= (rd[DIV_W +: DUR_W] == '0) ? DUR_W'(1) : rd[DIV_W +: DUR_W];
      rest_r <= rd[WD-1] | (rd[DIV_W-1:0] == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      tone_r <= 1'b0;
      step_r <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      len_r  <= '0;
      pre    <= '0;
      ticks  <= '0;
      tcnt   <= '0;
    end else begin
      done_r <= 1'b0;
      if ((state != IDLE) && bus.stop) begin
        state  <= IDLE;
        tone_r <= 1'b0;
        step_r <= '0;
        busy_r <= 1'b0;
        pre    <= '0;
        ticks  <= '0;
        tcnt   <= '0;
      end else if (adv) begin
        tone_r <= 1'b0;
        pre    <= '0;
        ticks  <= '0;
        if (!last_step) begin
          step_r <= step_r + 1'b1;
          state  <= LOAD;
        end else if (bus.loop) begin
          step_r <= '0;
          state  <= LOAD;
        end else begin
          state  <= DONE;
          done_r <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.stop) begin
              step_r <= '0;
              busy_r <= 1'b1;
              len_r  <= len_clamp;
              if (bus.len == '0) begin
                state  <= DONE;
                done_r <= 1'b1;
              end else begin
                state  <= LOAD;
              end
            end
          end
          LOAD: begin
            pre    <= '0;
            ticks  <= '0;
            tcnt   <= '0;
            tone_r <= 1'b0;
            state  <= PLAY;
          end
          PLAY: begin
            if (rest_r) begin
              tone_r <= 1'b0;
            end else if (tcnt == (half_r - 1'b1)) begin
              tcnt   <= '0;
              tone_r <= ~tone_r;
            end else begin
              tcnt   <= tcnt + 1'b1;
            end
            if (tick_wrap) begin
              pre <= '0;
              if (ticks == dur_last) begin
                ticks  <= '0;
                tone_r <= 1'b0;
                state  <= GAP;
              end else begin
                ticks  <= ticks + 1'b1;
              end
            end else begin
              pre <= pre + 1'b1;
            end
          end
          GAP: begin
            tone_r <= 1'b0;
            if (tick_wrap) begin
              pre   <= '0;
              ticks <= ticks + 1'b1;
            end else begin
              pre   <= pre + 1'b1;
            end
          end
          DONE: begin
            tone_r <= 1'b0;
            busy_r <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.tone = tone_r;
  assign bus.step = step_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule
